// File: rtl/ex_pkg.sv
// ex_pkg: shared ALU opcodes and datapath widths for the execute stage
package ex_pkg;
  localparam int XLEN = 32;
  localparam int REG_W = 5;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_NOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SLT = 4'd7
  } alu_op_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath with signed add/sub overflow detection
module alu_core
  import ex_pkg::*;
(
  input  logic [3:0]      alu_op,
  input  logic            use_sign,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      shamt,
  output logic [XLEN-1:0] result,
  output logic            overflow
);
  logic [XLEN-1:0] sum, diff;
  logic lt, ovf_add, ovf_sub;
  assign sum = a + b;
  assign diff = a - b;
  assign lt = use_sign ? ($signed(a) < $signed(b)) : (a < b);
  assign ovf_add = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
  assign ovf_sub = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
  assign overflow = use_sign && ((alu_op == ALU_ADD && ovf_add) || (alu_op == ALU_SUB && ovf_sub));
  // opcode select; codes 8-15 yield zero
  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD: result = sum;
      ALU_SUB: result = diff;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, lt};
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: ALU stage feeding EX/MEM; define EX_FORWARD_EN to build in the EX-to-EX bypass
module execute_stage
  import ex_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [3:0]       alu_op,
  input  logic             use_sign,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [4:0]       shamt,
  input  logic [REG_W-1:0] src_a,
  input  logic [REG_W-1:0] src_b,
  input  logic [REG_W-1:0] dest,
  input  logic             reg_write,
  input  logic             ovf_clear,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_result,
  output logic             ex_zero,
  output logic [REG_W-1:0] ex_dest,
  output logic             ex_reg_write,
  output logic             ex_overflow,
  output logic             ovf_sticky
);
  logic [XLEN-1:0] a, b, res;
  logic ovf, cap_ovf;
`ifdef EX_FORWARD_EN
  logic fwd_ok;
  assign fwd_ok = ex_valid && ex_reg_write && ex_dest != '0;
  assign a = (fwd_ok && src_a == ex_dest) ? ex_result : op_a;
  assign b = (fwd_ok && src_b == ex_dest) ? ex_result : op_b;
`else
  logic unused_src;
  assign unused_src = ^{src_a, src_b};
  assign a = op_a;
  assign b = op_b;
`endif
  alu_core u_alu (
    .alu_op   (alu_op),
    .use_sign (use_sign),
    .a        (a),
    .b        (b),
    .shamt    (shamt),
    .result   (res),
    .overflow (ovf)
  );
  assign cap_ovf = id_valid && ovf;
  // EX/MEM register: reset beats flush beats stall beats capture; sticky set wins over clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_result <= '0;
      ex_zero <= 1'b1;
      ex_dest <= '0;
      ex_reg_write <= 1'b0;
      ex_overflow <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ex_result <= '0;
      ex_zero <= 1'b1;
      ex_reg_write <= 1'b0;
      ex_overflow <= 1'b0;
      ovf_sticky <= ovf_sticky && !ovf_clear;
    end else if (stall) begin
      ovf_sticky <= ovf_sticky && !ovf_clear;
    end else begin
      ex_valid <= id_valid;
      ex_result <= res;
      ex_zero <= res == '0;
      ex_dest <= dest;
      ex_reg_write <= id_valid && reg_write && !ovf;
      ex_overflow <= cap_ovf;
      ovf_sticky <= cap_ovf || (ovf_sticky && !ovf_clear);
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed and randomized checks of execute_stage against a behavioural model
module tb_execute_stage;
  logic clk = 1'b0, rst = 1'b1, id_valid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [3:0] alu_op = '0;
  logic use_sign = 1'b0, reg_write = 1'b0, ovf_clear = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic [4:0] shamt = '0, src_a = '0, src_b = '0, dest = '0;
  logic ex_valid, ex_zero, ex_reg_write, ex_overflow, ovf_sticky;
  logic [31:0] ex_result;
  logic [4:0] ex_dest;
  int total = 0, passed = 0;
  logic m_valid, m_zero, m_rw, m_ovf, m_sticky, m_dest_known;
  logic [31:0] m_result;
  logic [4:0] m_dest;

  execute_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .stall(stall), .flush(flush),
    .alu_op(alu_op), .use_sign(use_sign), .op_a(op_a), .op_b(op_b), .shamt(shamt),
    .src_a(src_a), .src_b(src_b), .dest(dest), .reg_write(reg_write), .ovf_clear(ovf_clear),
    .ex_valid(ex_valid), .ex_result(ex_result), .ex_zero(ex_zero), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_overflow(ex_overflow), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic ref_alu(input logic [3:0] op, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] r, output logic v);
    longint sa, sb, full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    full = 0;
    v = 1'b0;
    case (op)
      4'd0: full = sa + sb;
      4'd1: full = sa - sb;
      default: full = 0;
    endcase
    r = 32'(full);
    if (op <= 4'd1) v = s && (full != longint'($signed(r)));
    if (op == 4'd2) r = a & b;
    if (op == 4'd3) r = a | b;
    if (op == 4'd4) r = ~(a | b);
    if (op == 4'd5) r = b << sh;
    if (op == 4'd6) r = b >> sh;
    if (op == 4'd7) r = (s ? (sa < sb) : (longint'({32'b0, a}) < longint'({32'b0, b}))) ? 32'd1 : 32'd0;
    if (op >= 4'd8) r = 32'd0;
  endtask

  task automatic model_edge();
    logic [31:0] a, b, r;
    logic v;
    if (rst) begin
      {m_valid, m_result, m_zero, m_dest, m_rw, m_ovf, m_sticky} = {1'b0, 32'd0, 1'b1, 5'd0, 3'b000};
      m_dest_known = 1'b1;
    end else if (flush) begin
      {m_valid, m_result, m_zero, m_rw, m_ovf} = {1'b0, 32'd0, 1'b1, 2'b00};
      m_dest_known = 1'b0;
      if (ovf_clear) m_sticky = 1'b0;
    end else if (stall) begin
      if (ovf_clear) m_sticky = 1'b0;
    end else begin
      a = op_a;
      b = op_b;
`ifdef EX_FORWARD_EN
      if (m_valid && m_rw && m_dest != 0 && src_a == m_dest) a = m_result;
      if (m_valid && m_rw && m_dest != 0 && src_b == m_dest) b = m_result;
`endif
      ref_alu(alu_op, use_sign, a, b, shamt, r, v);
      v = v && id_valid;
      m_valid = id_valid;
      m_result = r;
      m_zero = (r == 0);
      m_dest = dest;
      m_dest_known = 1'b1;
      m_rw = id_valid && reg_write && !v;
      m_ovf = v;
      if (v) m_sticky = 1'b1;
      else if (ovf_clear) m_sticky = 1'b0;
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, ".result"}, ex_result, m_result);
    chk({tag, ".zero"}, 32'(ex_zero), 32'(m_zero));
    if (m_dest_known) chk({tag, ".dest"}, 32'(ex_dest), 32'(m_dest));
    chk({tag, ".reg_write"}, 32'(ex_reg_write), 32'(m_rw));
    chk({tag, ".overflow"}, 32'(ex_overflow), 32'(m_ovf));
    chk({tag, ".sticky"}, 32'(ovf_sticky), 32'(m_sticky));
  endtask

  task automatic set_op(input logic [3:0] op, input logic s, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    {rst, stall, flush, ovf_clear} = 4'b0000;
    {id_valid, reg_write} = 2'b11;
    {alu_op, use_sign, op_a, op_b, shamt} = {op, s, a, b, sh};
    {src_a, src_b, dest} = {5'd0, 5'd0, 5'd1};
  endtask

  initial begin
    logic [31:0] pick [6];
    logic [31:0] fwd_exp;
    pick = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h5};
    {m_valid, m_result, m_zero, m_dest, m_rw, m_ovf, m_sticky, m_dest_known} = '0;
    rst = 1'b1;
    #1;
    step("reset");
    chk("reset.zero_const", 32'(ex_zero), 32'd1);
    chk("reset.result_const", ex_result, 32'd0);
    set_op(4'd0, 1'b1, 32'h7FFFFFFF, 32'd1, 5'd0);
    step("add_ovf");
    chk("add_ovf.flag", 32'(ex_overflow), 32'd1);
    chk("add_ovf.rw", 32'(ex_reg_write), 32'd0);
    chk("add_ovf.sticky", 32'(ovf_sticky), 32'd1);
    set_op(4'd0, 1'b0, 32'h7FFFFFFF, 32'd1, 5'd0);
    step("add_unsigned");
    chk("add_unsigned.result", ex_result, 32'h80000000);
    chk("add_unsigned.flag", 32'(ex_overflow), 32'd0);
    set_op(4'd7, 1'b1, 32'hFFFFFFFF, 32'd1, 5'd0);
    step("slt_signed");
    chk("slt_signed.result", ex_result, 32'd1);
    set_op(4'd7, 1'b0, 32'hFFFFFFFF, 32'd1, 5'd0);
    step("slt_unsigned");
    chk("slt_unsigned.result", ex_result, 32'd0);
    set_op(4'd5, 1'b0, 32'd0, 32'h1234, 5'd16);
    step("lui");
    chk("lui.result", ex_result, 32'h12340000);
    set_op(4'd1, 1'b1, 32'd5, 32'd5, 5'd0);
    step("sub_zero");
    stall = 1'b1;
    op_a = 32'd99;
    for (int i = 0; i < 3; i++) begin
      step("stall_hold");
      chk("stall_hold.result", ex_result, 32'd0);
      chk("stall_hold.zero", 32'(ex_zero), 32'd1);
    end
    flush = 1'b1;
    step("stall_flush");
    chk("stall_flush.valid", 32'(ex_valid), 32'd0);
    set_op(4'd9, 1'b0, 32'd3, 32'd4, 5'd0);
    step("op_hi");
    chk("op_hi.result", ex_result, 32'd0);
    set_op(4'd1, 1'b1, 32'h80000000, 32'd1, 5'd0);
    ovf_clear = 1'b1;
    step("clear_vs_set");
    chk("clear_vs_set.sticky", 32'(ovf_sticky), 32'd1);
    set_op(4'd2, 1'b0, 32'hF0F0, 32'hFF00, 5'd0);
    ovf_clear = 1'b1;
    step("clear");
    chk("clear.sticky", 32'(ovf_sticky), 32'd0);
    set_op(4'd3, 1'b0, 32'h1, 32'h2, 5'd0);
    step("pre_rst");
    rst = 1'b1;
    step("mid_rst");
    chk("mid_rst.valid", 32'(ex_valid), 32'd0);
    set_op(4'd4, 1'b0, 32'h0, 32'h0, 5'd0);
    step("after_rst");
    chk("after_rst.result", ex_result, 32'hFFFFFFFF);
`ifdef EX_FORWARD_EN
    fwd_exp = 32'd11;
`else
    fwd_exp = 32'd1;
`endif
    set_op(4'd0, 1'b0, 32'd4, 32'd6, 5'd0);
    dest = 5'd3;
    step("fwd_i1");
    set_op(4'd0, 1'b0, 32'd0, 32'd1, 5'd0);
    src_a = 5'd3;
    step("fwd_i2");
    chk("fwd_i2.result", ex_result, fwd_exp);
    set_op(4'd0, 1'b0, 32'd4, 32'd6, 5'd0);
    dest = 5'd0;
    step("fwd0_i1");
    set_op(4'd0, 1'b0, 32'd0, 32'd1, 5'd0);
    src_a = 5'd0;
    step("fwd0_i2");
    chk("fwd0_i2.result", ex_result, 32'd1);
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      flush = ($urandom_range(0, 9) == 0);
      stall = ($urandom_range(0, 5) == 0);
      ovf_clear = ($urandom_range(0, 7) == 0);
      id_valid = ($urandom_range(0, 3) != 0);
      reg_write = 1'($urandom);
      alu_op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      use_sign = 1'($urandom);
      op_a = $urandom_range(0, 1) ? $urandom : pick[$urandom_range(0, 5)];
      op_b = $urandom_range(0, 1) ? $urandom : pick[$urandom_range(0, 5)];
      shamt = 5'($urandom);
      src_a = 5'($urandom_range(0, 3));
      src_b = 5'($urandom_range(0, 3));
      dest = 5'($urandom_range(0, 3));
      step("rand");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
